// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a power-of-2 write FIFO, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between D7 and STOP.
module uart_tx #(
  parameter int clk_frequence = 5_000_000,
  parameter int baud_rate     = 9600,
  parameter int fifo_depth    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic       tx,
  output logic       tx_busy,
  output logic       fifo_full,
  output logic       po_done
);

  localparam int cnt_baud_max = clk_frequence / baud_rate;
  localparam int CW = (cnt_baud_max > 1) ? $clog2(cnt_baud_max) : 1;
  localparam int AW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(cnt_baud_max - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(fifo_depth);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic [7:0]      mem [fifo_depth];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [AW:0]     count_next;
  logic            push;
  logic            pop;
  logic            bit_end;
  logic [7:0]      head;
`ifdef UART_TX_PARITY_EN
  logic            par_bit;
`endif

  assign head = mem[rd_ptr];

  // fifo_full mirrors the registered count, so a push against a full FIFO is
  // rejected even if the same cycle pops.
  always_comb begin
    push       = pi_flag && !fifo_full;
    bit_end    = (cnt == CNT_LAST);
    pop        = (count != '0) &&
                 ((state == IDLE) || ((state == STOP) && bit_end));
    count_next = count;
    if (push && !pop)
      count_next = count + CNT_ONE;
    else if (!push && pop)
      count_next = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= pi_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      fifo_full <= 1'b0;
      po_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      count     <= count_next;
      fifo_full <= (count_next == FULL_CNT);
      tx_busy   <= (state != IDLE) || (count != '0);
      po_done   <= (state == STOP) && bit_end;

      if ((state == IDLE) || bit_end)
        cnt <= '0;
      else
        cnt <= cnt + CW'(1);

      // tx is driven from the current state, so the line lags the FSM by one clock.
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift   <= head;
            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit <= ^head;
`endif
            state   <= START;
          end
        end
        START: begin
          tx <= 1'b0;
          if (bit_end)
            state <= DATA;
        end
        DATA: begin
          tx <= shift[0];
          if (bit_end) begin
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx <= par_bit;
          if (bit_end)
            state <= STOP;
        end
`endif
        STOP: begin
          tx <= 1'b1;
          if (bit_end) begin
            if (pop) begin
              shift   <= head;
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              par_bit <= ^head;
`endif
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at 10 clocks per bit.
module tb_uart_tx;

  localparam int BPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] pi_data;
  logic       pi_flag;
  logic       tx;
  logic       tx_busy;
  logic       fifo_full;
  logic       po_done;

  int n_asserts = 0;
  int n_fail    = 0;
  int done_cnt  = 0;
  logic [7:0] rx_q [$];

  uart_tx #(
    .clk_frequence(1_000_000),
    .baud_rate    (100_000),
    .fifo_depth   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pi_data  (pi_data),
    .pi_flag  (pi_flag),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .fifo_full(fifo_full),
    .po_done  (po_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n === 1'b1 && po_done === 1'b1)
      done_cnt++;

  // Line decoder: samples each bit at its centre and queues received bytes.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        repeat (BPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BPB) @(negedge clk);
          b[i] = tx;
        end
        repeat ((NBITS - 9) * BPB) @(negedge clk);
        rx_q.push_back(b);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    pi_data = b;
    pi_flag = 1'b1;
    tick();
    pi_flag = 1'b0;
  endtask

  // Called on frame clock 1 (tx just fell); returns on the last frame clock.
  task automatic check_frame(input logic [7:0] b, input logic par, input string nm);
    logic [10:0] bits;
    logic        exp_done;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    bits[9] = par;
`else
    bits[10] = par;
`endif
    for (int i = 0; i < NBITS * BPB; i++) begin
      if (i > 0) tick();
      n_asserts++;
      if (tx !== bits[i / BPB]) begin
        n_fail++;
        $display("FAIL %s tx at frame clock %0d: got %b expected %b", nm, i + 1, tx, bits[i / BPB]);
      end
      exp_done = (i == NBITS * BPB - 1);
      n_asserts++;
      if (po_done !== exp_done) begin
        n_fail++;
        $display("FAIL %s po_done at frame clock %0d: got %b expected %b", nm, i + 1, po_done, exp_done);
      end
      if (i == 50) begin
        n_asserts++;
        if (tx_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s tx_busy mid-frame: got %b expected 1", nm, tx_busy);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    pi_flag = 1'b0;
    pi_data = '0;
    repeat (3) tick();
    n_asserts++; if (tx !== 1'b1)        begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    n_asserts++; if (tx_busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b expected 0", tx_busy); end
    n_asserts++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", fifo_full); end
    n_asserts++; if (po_done !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b expected 0", po_done); end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single();
    int d0;
    rx_q.delete();
    d0 = done_cnt;
    send_byte(8'hA5);
    tick();
    n_asserts++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL single_pre_start tx: got %b expected 1", tx); end
    tick();
    check_frame(8'hA5, 1'b0, "single_A5");
    repeat (3) tick();
    n_asserts++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b expected 0", tx_busy); end
    n_asserts++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL single_done_count: got %0d expected 1", done_cnt - d0); end
    n_asserts++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_rx: got %0d bytes first %h expected 1 byte a5", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    logic [7:0] exp [3];
    exp = '{8'h00, 8'hFF, 8'h55};
    rx_q.delete();
    d0 = done_cnt;
    pi_flag = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pi_data = exp[k];
      tick();
    end
    pi_flag = 1'b0;
    check_frame(8'h00, 1'b0, "b2b_00");
    tick();
    check_frame(8'hFF, 1'b0, "b2b_FF");
    tick();
    check_frame(8'h55, 1'b0, "b2b_55");
    tick();
    n_asserts++; if (tx !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_after: got %b expected 1", tx); end
    repeat (2) tick();
    n_asserts++; if (done_cnt - d0 !== 3) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 3", done_cnt - d0); end
    n_asserts++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_after: got %b expected 0", tx_busy); end
    n_asserts++;
    if (rx_q.size() != 3) begin
      n_fail++; $display("FAIL b2b_rx_count: got %0d expected 3", rx_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_asserts++;
        if (rx_q[k] !== exp[k]) begin n_fail++; $display("FAIL b2b_rx[%0d]: got %h expected %h", k, rx_q[k], exp[k]); end
      end
    end
  endtask

  task automatic test_fifo_full();
    int d0;
    int waited;
    logic [7:0] bytes [6];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    rx_q.delete();
    d0 = done_cnt;
    pi_flag = 1'b1;
    for (int k = 0; k < 6; k++) begin
      pi_data = bytes[k];
      tick();
      if (k == 3) begin
        n_asserts++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL burst_full_after_w4: got %b expected 0", fifo_full); end
      end
      if (k >= 4) begin
        n_asserts++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL burst_full_after_w%0d: got %b expected 1", k + 1, fifo_full); end
      end
    end
    pi_flag = 1'b0;
    waited = 0;
    while (tx_busy === 1'b1 && waited < 1000) begin
      tick();
      waited++;
    end
    n_asserts++; if (waited >= 1000) begin n_fail++; $display("FAIL burst_drain_timeout: got busy after %0d clocks expected idle", waited); end
    tick();
    n_asserts++; if (done_cnt - d0 !== 5) begin n_fail++; $display("FAIL burst_done_count: got %0d expected 5", done_cnt - d0); end
    n_asserts++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL burst_full_after_drain: got %b expected 0", fifo_full); end
    n_asserts++;
    if (rx_q.size() != 5) begin
      n_fail++; $display("FAIL burst_rx_count: got %0d expected 5", rx_q.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_asserts++;
        if (rx_q[k] !== bytes[k]) begin n_fail++; $display("FAIL burst_rx[%0d]: got %h expected %h", k, rx_q[k], bytes[k]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    logic saw_low;
    logic saw_busy;
    pi_flag = 1'b1;
    pi_data = 8'h3C; tick();
    pi_data = 8'h81; tick();
    pi_data = 8'h42; tick();
    pi_flag = 1'b0;
    n_asserts++; if (tx !== 1'b0) begin n_fail++; $display("FAIL rstmid_start: got %b expected 0", tx); end
    repeat (44) tick();
    n_asserts++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b expected 1", tx_busy); end
    #1 rst_n = 1'b0;
    #1;
    n_asserts++; if (tx !== 1'b1)        begin n_fail++; $display("FAIL rstmid_tx: got %b expected 1", tx); end
    n_asserts++; if (tx_busy !== 1'b0)   begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", tx_busy); end
    n_asserts++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL rstmid_full: got %b expected 0", fifo_full); end
    repeat (2) tick();
    rst_n = 1'b1;
    d0 = done_cnt;
    saw_low  = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (tx !== 1'b1) saw_low = 1'b1;
      if (tx_busy !== 1'b0) saw_busy = 1'b1;
    end
    n_asserts++; if (saw_low !== 1'b0)  begin n_fail++; $display("FAIL rstmid_no_frames: got tx low %b expected 0", saw_low); end
    n_asserts++; if (saw_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_after: got %b expected 0", saw_busy); end
    n_asserts++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL rstmid_done_count: got %0d expected 0", done_cnt - d0); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    send_byte(8'h07);
    tick();
    tick();
    check_frame(8'h07, 1'b1, "parity_07");
    repeat (3) tick();
    send_byte(8'h03);
    tick();
    tick();
    check_frame(8'h03, 1'b0, "parity_03");
    repeat (3) tick();
    n_asserts++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL parity_busy_after: got %b expected 0", tx_busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
